first_nios2_system_sysid_checker: RTL and testbench
===================================================

# first_nios2_system_sysid_checker

Avalon-MM read master that interrogates the system-ID slave at boot, before the Nios II processor is released, or on demand. It reads the ID word (word address 0) and the timestamp word (word address 1), compares each against build-time expected values, and reports pass/fail/timeout. It gives hardware a way to reject a mismatched FPGA image without software involvement. It sits on the system interconnect as a second master alongside the CPU.

## Interface

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected value at word address 0
- EXPECTED_TIMESTAMP, 32'd1431472893, expected value at word address 1
- TIMEOUT_CYCLES, 255, maximum cycles per read attempt (issue to readdatavalid), range 1..65535
- MAX_RETRIES, 3, extra attempts per word after a timeout, range 0..15

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- master_address  out  1  word address (0 = ID, 1 = timestamp)
- master_read  out  1  Avalon read request
- master_waitrequest  in  1  slave stall; request is held while high
- master_readdatavalid  in  1  response valid
- master_readdata  in  32  response data
- busy  out  1  check in progress
- done  out  1  high from check completion until the next accepted start or reset
- id_ok  out  1  ID matched; valid while done
- ts_ok  out  1  timestamp matched; valid while done
- timeout_err  out  1  retries exhausted on some word; valid while done
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation

- States:
  - IDLE: wait for start.
  - RD_ID: master_read=1, address=0.
  - WT_ID: waiting for response.
  - RD_TS / WT_TS: the same two states for address 1.
  - DONE.
- IDLE or DONE + start → RD_ID. Entering RD_ID clears id_ok, ts_ok, timeout_err, done, the retry count and the timeout counter.
- RD_x:
  - Hold master_read and master_address stable while master_waitrequest=1.
  - Request accepted (read & !waitrequest): go to WT_x, unless readdatavalid is also high that cycle. In that case capture the data and advance directly.
- WT_x:
  - On readdatavalid, capture master_readdata into x_value and set x_ok = (data == EXPECTED_x).
  - After capture: RD_ID → RD_TS; the TS capture → DONE.
- Timeout:
  - The counter increments every cycle in RD_x/WT_x and resets on each new attempt.
  - When the count reaches TIMEOUT_CYCLES without a capture: if retries < MAX_RETRIES, increment retries and re-enter RD_x; otherwise set timeout_err and go to DONE. In that case x_ok=0, and ts_ok=0 if the timeout occurred on the ID read.
  - The retry count resets when moving from ID to TS.
  - A timeout during RD_x drops master_read, even mid-waitrequest. This is a deliberate Avalon violation, allowed only on a hung fabric. Document it at integration.
- readdatavalid in IDLE or DONE is ignored.
- A stray readdatavalid in RD/WT is taken as the current response. This is a known limitation: a late response after a timeout can alias.
- A mismatch does not stop the sequence; both words are always read.

## Timing

- Reset values:
  - master_read=0, master_address=0.
  - busy=0, done=0, id_ok=0, ts_ok=0, timeout_err=0.
  - id_value=0, ts_value=0.
  - State = IDLE, counters = 0.
- All outputs are registered; no combinational path from any input to any output.
- Zero-wait slave with readdatavalid in the acceptance cycle:
  - start at cycle 0.
  - Read of address 0 at cycle 1.
  - Read of address 1 at cycle 2.
  - done=1 and flags valid at cycle 3.
  - busy=1 in cycles 1–2.
- Each waitrequest cycle adds one cycle. Each cycle of readdatavalid latency adds one cycle.
- Worst-case duration: 2·(MAX_RETRIES+1)·TIMEOUT_CYCLES + 1 cycles.
- reset mid-check wins over all other inputs: state returns to IDLE on the next edge and master_read deasserts.
- start in the same cycle as reset is ignored.
- busy and done are never both high.

## Structure

- Package first_nios2_system_pkg holds:
  - the state enum;
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - the 32-bit data width constant.
- Sub-module first_nios2_system_timeout_ctr: a loadable, saturating down-counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Width: $clog2(TIMEOUT_CYCLES+1).
  - It is instantiated once for the timeout. The retry count stays inline.

## Test plan

- Zero-wait slave returning 0 / 1431472893, one start → done at cycle 3, id_ok=1, ts_ok=1, timeout_err=0, master_read high exactly 2 cycles.
- Slave holds waitrequest 4 cycles per read, readdatavalid 2 cycles after acceptance → done at cycle 15, read/address stable during stalls, both ok.
- Timestamp returns 32'hDEADBEEF → done, id_ok=1, ts_ok=0, ts_value=32'hDEADBEEF, timeout_err=0.
- TIMEOUT_CYCLES=8, MAX_RETRIES=2, slave never responds → exactly 3 ID attempts, done at cycle 25, timeout_err=1, id_ok=0, ts_ok=0, no TS read issued.
- reset asserted mid-WT_TS, then start after deassert → outputs at reset values after the reset edge, then a clean full check passes; start pulses while busy are ignored.

Source files
------------

// File: rtl/first_nios2_system_pkg.sv
// first_nios2_system_pkg: shared types and constants for the system-ID checker
// Contents: checker state enum, word addresses of the sysid slave, data width, state helper.
package first_nios2_system_pkg;
    localparam int SYSID_DATA_W = 32;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_RD_ID, ST_WT_ID, ST_RD_TS, ST_WT_TS, ST_DONE} state_e;
    function automatic logic st_active(state_e s);
        return s inside {ST_RD_ID, ST_WT_ID, ST_RD_TS, ST_WT_TS};
    endfunction
endpackage

// File: rtl/first_nios2_system_timeout_ctr.sv
// first_nios2_system_timeout_ctr: loadable saturating down-counter for per-attempt read timeout
// Ports: clock_i/reset_i (sync, active-high), clear_i reloads TIMEOUT_CYCLES, enable_i counts down,
//        expired_o flags the last cycle of the attempt window.
module first_nios2_system_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? W'(TIMEOUT_CYCLES) : (enable_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clock_i) begin
        if (reset_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // Loaded at attempt entry, so a value of 1 marks the TIMEOUT_CYCLES-th cycle of the attempt.
    assign expired_o = cnt_q <= W'(1);
endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker: Avalon-MM master that reads sysid ID/timestamp and reports pass/fail/timeout
// Ports: clock/reset (sync, active-high); start launches a check; master_* is the Avalon read master;
//        busy/done status; id_ok/ts_ok/timeout_err valid while done; id_value/ts_value last captured words.
module first_nios2_system_sysid_checker
    import first_nios2_system_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1431472893,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    master_address,
    output logic                    master_read,
    input  logic                    master_waitrequest,
    input  logic                    master_readdatavalid,
    input  logic [SYSID_DATA_W-1:0] master_readdata,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout_err,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value
);
    state_e state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic new_att, capture, give_up, launch, is_ts, in_rd, expired;
    logic read_q, addr_q, busy_q, done_q, id_ok_q, ts_ok_q, terr_q;
    logic [SYSID_DATA_W-1:0] id_value_q, ts_value_q;
    first_nios2_system_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clock_i  (clock),
        .reset_i  (reset),
        .clear_i  (new_att),
        .enable_i (st_active(state_q)),
        .expired_o(expired)
    );
    // Any readdatavalid while a read is outstanding is taken as the answer, even during
    // waitrequest; a capture in the last window cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        new_att = 1'b0;
        capture = 1'b0;
        give_up = 1'b0;
        is_ts = state_q inside {ST_RD_TS, ST_WT_TS};
        in_rd = state_q inside {ST_RD_ID, ST_RD_TS};
        launch = !st_active(state_q) && start;
        if (launch) begin
            state_d = ST_RD_ID;
            new_att = 1'b1;
            retry_d = '0;
        end else if (st_active(state_q) && master_readdatavalid) begin
            capture = 1'b1;
            state_d = is_ts ? ST_DONE : ST_RD_TS;
            new_att = !is_ts;
            retry_d = '0;
        end else if (st_active(state_q) && expired) begin
            if (retry_q < 4'(MAX_RETRIES)) begin
                retry_d = retry_q + 4'd1;
                state_d = is_ts ? ST_RD_TS : ST_RD_ID;
                new_att = 1'b1;
            end else begin
                give_up = 1'b1;
                state_d = ST_DONE;
            end
        end else if (in_rd && !master_waitrequest) begin
            state_d = is_ts ? ST_WT_TS : ST_WT_ID;
        end
    end
    // Outputs are registered from the next state; a final timeout in RD_x drops the read
    // even under waitrequest, which is only acceptable on a hung fabric.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            read_q <= 1'b0;
            addr_q <= SYSID_ADDR_ID;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            terr_q <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            read_q <= state_d inside {ST_RD_ID, ST_RD_TS};
            addr_q <= (state_d inside {ST_RD_TS, ST_WT_TS}) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy_q <= st_active(state_d);
            done_q <= state_d == ST_DONE;
            if (launch) begin
                id_ok_q <= 1'b0;
                ts_ok_q <= 1'b0;
                terr_q <= 1'b0;
            end
            if (capture && !is_ts) begin
                id_value_q <= master_readdata;
                id_ok_q <= master_readdata == EXPECTED_ID;
            end
            if (capture && is_ts) begin
                ts_value_q <= master_readdata;
                ts_ok_q <= master_readdata == EXPECTED_TIMESTAMP;
            end
            if (give_up) begin
                terr_q <= 1'b1;
                ts_ok_q <= 1'b0;
                if (!is_ts) id_ok_q <= 1'b0;
            end
        end
    end
    assign master_read = read_q;
    assign master_address = addr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign id_ok = id_ok_q;
    assign ts_ok = ts_ok_q;
    assign timeout_err = terr_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;
endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb_first_nios2_system_sysid_checker: directed checks of the sysid checker against an attempt-level model
module tb_first_nios2_system_sysid_checker;
    localparam int T = 8;
    localparam int R = 2;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1431472893;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic master_address, master_read, busy, done, id_ok, ts_ok, timeout_err;
    logic wr = 1'b0, rdv = 1'b0;
    logic [31:0] rdata = '0, id_value, ts_value;
    int vectors = 0, miscompares = 0;
    int s_w = 0, s_l = 0;
    bit s_idr = 1'b0, s_tsr = 1'b0;
    logic [31:0] s_id = '0, s_ts = '0;
    bit exp_rd [0:299];
    bit exp_ad [0:299];
    int done_cyc = 0, cyc = 0, done_seen = 0, accepts = 0, rdcyc = 0;
    bit active = 1'b0;
    bit e_idok, e_tsok, e_terr;
    logic [31:0] last_id = '0, last_ts = '0;
    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(T), .MAX_RETRIES(R)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .master_address(master_address), .master_read(master_read),
        .master_waitrequest(wr), .master_readdatavalid(rdv), .master_readdata(rdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
        .id_value(id_value), .ts_value(ts_value)
    );
    always #5 clock = ~clock;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // Slave: s_w waitrequest cycles per request, answer s_l cycles after acceptance (0 = same cycle).
    initial begin
        int wleft = 0, lleft = 0;
        bit in_req = 1'b0, paddr = 1'b0;
        forever begin
            @(negedge clock);
            rdv = 1'b0;
            wr = 1'b0;
            if (lleft > 0) begin
                lleft--;
                if (lleft == 0) begin
                    rdv = 1'b1;
                    rdata = paddr ? s_ts : s_id;
                end
            end
            if (master_read) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wleft = s_w;
                end
                if (wleft > 0) begin
                    wr = 1'b1;
                    wleft--;
                end else begin
                    in_req = 1'b0;
                    if (master_address ? s_tsr : s_idr) begin
                        if (s_l == 0) begin
                            rdv = 1'b1;
                            rdata = master_address ? s_ts : s_id;
                        end else begin
                            lleft = s_l;
                            paddr = master_address;
                        end
                    end
                end
            end
        end
    end
    // Compare process: cycle 1 is the first cycle after the start cycle.
    always @(posedge clock) begin
        #1;
        if (active) begin
            cyc++;
            chk("busy", busy, 32'(cyc < done_cyc));
            chk("done", done, 32'(cyc >= done_cyc));
            chk("busy_and_done", busy & done, 0);
            if (cyc < 300) chk("read", master_read, exp_rd[cyc]);
            if (cyc < 300 && exp_rd[cyc]) chk("address", master_address, exp_ad[cyc]);
            if (master_read && !wr) accepts++;
            if (master_read) rdcyc++;
            if (done && done_seen == 0) done_seen = cyc;
            if (cyc == done_cyc) begin
                chk("id_ok", id_ok, e_idok);
                chk("ts_ok", ts_ok, e_tsok);
                chk("timeout_err", timeout_err, e_terr);
                chk("id_value", id_value, last_id);
                chk("ts_value", ts_value, last_ts);
                active = 1'b0;
            end
        end
    end
    // Model: a list of attempts; a responding attempt lasts w+1+l cycles, a silent one T cycles.
    task automatic arm(input int w, input int l, input bit idr, input bit tsr, input logic [31:0] idd, input logic [31:0] tsd);
        int s;
        @(negedge clock);
        s_w = w; s_l = l; s_idr = idr; s_tsr = tsr; s_id = idd; s_ts = tsd;
        for (int i = 0; i < 300; i++) begin
            exp_rd[i] = 1'b0;
            exp_ad[i] = 1'b0;
        end
        s = 1;
        for (int wd = 0; wd < 2; wd++) begin
            bit resp;
            resp = (wd == 1) ? tsr : idr;
            if (wd == 1 && !idr) break;
            for (int a = 0; a < (resp ? 1 : R + 1); a++) begin
                for (int c = s; c <= s + w; c++) begin
                    exp_rd[c] = 1'b1;
                    exp_ad[c] = (wd == 1);
                end
                s += resp ? w + 1 + l : T;
            end
        end
        done_cyc = s;
        e_idok = idr && idd == EXP_ID;
        e_tsok = idr && tsr && tsd == EXP_TS;
        e_terr = !idr || !tsr;
        if (idr) last_id = idd;
        if (idr && tsr) last_ts = tsd;
        cyc = 0; done_seen = 0; accepts = 0; rdcyc = 0;
        active = 1'b1;
        start = 1'b1;
    endtask
    task automatic run_check(input int w, input int l, input bit idr, input bit tsr, input logic [31:0] idd, input logic [31:0] tsd, input int pulse);
        arm(w, l, idr, tsr, idd, tsd);
        for (int i = 0; i < 300 && active; i++) begin
            @(negedge clock);
            start = (pulse > 0 && cyc == pulse);
        end
        start = 1'b0;
        if (active) begin
            chk("cycle_bound", cyc, done_cyc);
            active = 1'b0;
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_read"}, master_read, 0);
        chk({tag, "_address"}, master_address, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flags"}, {id_ok, ts_ok, timeout_err}, 0);
        chk({tag, "_id_value"}, id_value, 0);
        chk({tag, "_ts_value"}, ts_value, 0);
    endtask
    initial begin
        repeat (3) @(negedge clock);
        chk_reset("por");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_check(0, 0, 1, 1, EXP_ID, EXP_TS, 0);
        chk("t1_done_cycle", done_seen, 3);
        chk("t1_read_cycles", rdcyc, 2);
        chk("t1_flags", {id_ok, ts_ok, timeout_err}, 3'b110);
        run_check(4, 2, 1, 1, EXP_ID, EXP_TS, 0);
        chk("t2_done_cycle", done_seen, 15);
        chk("t2_read_cycles", rdcyc, 10);
        run_check(0, 1, 1, 1, EXP_ID, 32'hDEADBEEF, 0);
        chk("t3_ts_value", ts_value, 32'hDEADBEEF);
        chk("t3_flags", {id_ok, ts_ok, timeout_err}, 3'b100);
        run_check(0, 0, 0, 1, EXP_ID, EXP_TS, 0);
        chk("t4_done_cycle", done_seen, 25);
        chk("t4_id_attempts", accepts, 3);
        chk("t4_flags", {id_ok, ts_ok, timeout_err}, 3'b001);
        run_check(0, 0, 1, 0, EXP_ID, EXP_TS, 0);
        chk("t5_done_cycle", done_seen, 26);
        chk("t5_ts_value_kept", ts_value, 32'hDEADBEEF);
        run_check(1, 0, 1, 1, 32'h1234_5678, EXP_TS, 2);
        chk("t6_done_cycle", done_seen, 5);
        chk("t6_flags", {id_ok, ts_ok, timeout_err}, 3'b010);
        arm(4, 2, 1, 1, EXP_ID, EXP_TS);
        for (int i = 0; i < 50 && cyc < 13; i++) begin
            @(negedge clock);
            start = (cyc == 9);
        end
        chk("t7_reached_wt_ts", cyc, 13);
        reset = 1'b1;
        start = 1'b1;
        active = 1'b0;
        @(negedge clock);
        chk_reset("mid_rst");
        reset = 1'b0;
        start = 1'b0;
        last_id = '0;
        last_ts = '0;
        @(negedge clock);
        chk_reset("post_rst");
        run_check(0, 0, 1, 1, EXP_ID, EXP_TS, 0);
        chk("t8_done_cycle", done_seen, 3);
        chk("t8_flags", {id_ok, ts_ok, timeout_err}, 3'b110);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
